// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  localparam int NCO_W           = 17;
  localparam int OVERSAMPLE      = 16;
  localparam int MID_SAMPLE      = 7;
  localparam int SYS_CLK_DEFAULT = 100_000_000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  // Even parity of a byte: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_nco.sv
// 16x oversample tick generator. The low 16 bits of the accumulator are the
// phase; bit 16 receives the carry, so each rising edge of bit 16 marks one
// oversample period. Clearing restarts the phase at a start edge.
// Optional feature macro: UART_RX_PARITY_EN (not used in this file).
module uart_nco
  import uart_pkg::*;
#(
  parameter int DEFAULT_BDR = 115200,
  parameter int SYS_CLK     = SYS_CLK_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [63:0] INC_WIDE =
    (64'(DEFAULT_BDR) * 64'(OVERSAMPLE) * 64'd65536) / 64'(SYS_CLK);
  localparam logic [NCO_W-1:0] INC = INC_WIDE[NCO_W-1:0];

  logic [NCO_W-1:0] acc_r;
  logic [NCO_W-1:0] acc_nxt_s;
  logic             tick_r;

  // Next accumulator value: clear, advance by INC, or hold.
  always_comb begin
    acc_nxt_s = acc_r;
    if (clr) begin
      acc_nxt_s = {NCO_W{1'b0}};
    end else if (en) begin
      acc_nxt_s = {1'b0, acc_r[NCO_W-2:0]} + INC;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Accumulator register and registered rising-edge detect on the carry bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {NCO_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      acc_r  <= acc_nxt_s;
      tick_r <= acc_nxt_s[NCO_W-1] & ~acc_r[NCO_W-1];
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop input synchronizer, NCO-driven 16x oversampling,
// mid-bit sampling FSM, LSB-first shift register and registered status pulses.
// Optional feature macro: UART_RX_PARITY_EN (one even-parity bit after D7).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DEFAULT_BDR = 115200,
  parameter int SYS_CLK     = SYS_CLK_DEFAULT,
  parameter int STOP_BIT    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  // Only the first stop bit is checked; extra stop bits are plain idle time.
  if (STOP_BIT < 1) begin : g_bad_stop_bit
    $error("STOP_BIT must be at least 1");
  end

  state_t      state_r, state_nxt_s;
  logic        rxd_meta_r, rxd_sync_r;
  logic [3:0]  tick_cnt_r, tick_cnt_nxt_s;
  logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]  shift_r, shift_nxt_s;
  logic [7:0]  data_r, data_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        ferr_r, ferr_nxt_s;
  logic        busy_r;
  logic        tick_s, mid_s, nco_en_s, nco_clr_s;
`ifdef UART_RX_PARITY_EN
  logic        perr_r, perr_nxt_s;
  logic        pflag_r, pflag_nxt_s;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  assign nco_clr_s = (state_r == IDLE);
  assign nco_en_s  = (state_r != IDLE) && (state_r != WAIT_IDLE);
  assign mid_s     = tick_s && (tick_cnt_r == 4'(MID_SAMPLE));

  uart_nco #(
    .DEFAULT_BDR (DEFAULT_BDR),
    .SYS_CLK     (SYS_CLK)
  ) u_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (nco_en_s),
    .clr   (nco_clr_s),
    .tick  (tick_s)
  );

  // Tick counter: held at 0 in IDLE, wraps 15->0 at every bit boundary.
  always_comb begin
    tick_cnt_nxt_s = tick_cnt_r;
    if (state_r == IDLE) begin
      tick_cnt_nxt_s = 4'd0;
    end else if (tick_s) begin
      tick_cnt_nxt_s = tick_cnt_r + 4'd1;
    end else begin
      tick_cnt_nxt_s = tick_cnt_r;
    end
  end

  // Next-state, shift register and output pulse logic.
  always_comb begin
    state_nxt_s   = state_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    data_nxt_s    = data_r;
    valid_nxt_s   = 1'b0;
    ferr_nxt_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt_s    = 1'b0;
    pflag_nxt_s   = pflag_r;
`endif
    case (state_r)
      IDLE: begin
        bit_cnt_nxt_s = 3'd0;
`ifdef UART_RX_PARITY_EN
        pflag_nxt_s   = 1'b0;
`endif
        if (!rxd_sync_r) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (mid_s) begin
          if (rxd_sync_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (mid_s) begin
          shift_nxt_s   = {rxd_sync_r, shift_r[7:1]};
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = STOP;
`endif
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_s) begin
          pflag_nxt_s = rxd_sync_r ^ even_parity(shift_r);
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (mid_s) begin
          if (rxd_sync_r) begin
            data_nxt_s  = shift_r;
            valid_nxt_s = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_nxt_s  = pflag_r;
`endif
            state_nxt_s = IDLE;
          end else begin
            ferr_nxt_s  = 1'b1;
            state_nxt_s = WAIT_IDLE;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      WAIT_IDLE: begin
        if (rxd_sync_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      tick_cnt_r <= 4'd0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      data_r     <= 8'h00;
      valid_r    <= 1'b0;
      ferr_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      data_r     <= data_nxt_s;
      valid_r    <= valid_nxt_s;
      ferr_r     <= ferr_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch flag for the current frame and its output pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pflag_r <= 1'b0;
      perr_r  <= 1'b0;
    end else begin
      pflag_r <= pflag_nxt_s;
      perr_r  <= perr_nxt_s;
    end
  end

  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver. One instance runs at the default
// 115200 bd, a second at 2 Mbd for the longer random traffic; a single serial
// line is routed to whichever instance is active, the other sees idle high.
// Optional feature macro: UART_RX_PARITY_EN (parity frames are then sent).
module tb_uart_receiver;

  localparam int FAST_BDR  = 2_000_000;
  localparam int SLOW_BIT  = 868;
  localparam int FAST_BIT  = 50;
  localparam int STOP_BITS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic       use_fast = 1'b0;
  logic       rxd_slow, rxd_fast;
  logic [7:0] data_s, data_f;
  logic       v_s, fe_s, pe_s, b_s;
  logic       v_f, fe_f, pe_f, b_f;

  int total = 0;
  int bad   = 0;
  int ev_cnt = 0;
  int pushed_cnt = 0;

  typedef struct {
    logic [7:0] b;
    bit         ferr;
    bit         perr;
  } exp_t;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] last_good [2];

  always #5 clk = ~clk;

  assign rxd_slow = use_fast ? 1'b1 : line;
  assign rxd_fast = use_fast ? line : 1'b1;

  uart_receiver dut_slow (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_slow), .data(data_s),
    .valid(v_s), .frame_err(fe_s), .parity_err(pe_s), .busy(b_s)
  );

  uart_receiver #(.DEFAULT_BDR(FAST_BDR)) dut_fast (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_fast), .data(data_f),
    .valid(v_f), .frame_err(fe_f), .parity_err(pe_f), .busy(b_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every status pulse is matched against the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [7:0] m_data;
      logic m_v, m_fe, m_pe, other;
      m_data = use_fast ? data_f : data_s;
      m_v    = use_fast ? v_f  : v_s;
      m_fe   = use_fast ? fe_f : fe_s;
      m_pe   = use_fast ? pe_f : pe_s;
      other  = use_fast ? (v_s | fe_s | pe_s) : (v_f | fe_f | pe_f);
      if (other) check_eq("idle_instance_pulse", 32'd1, 32'd0);
      if (m_v || m_fe || m_pe) begin
        ev_cnt++;
        check_eq("pulse_exclusive", 32'(m_fe & (m_v | m_pe)), 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("valid", 32'(m_v), 32'(!mon_e.ferr));
          check_eq("frame_err", 32'(m_fe), 32'(mon_e.ferr));
          check_eq("parity_err", 32'(m_pe), 32'(mon_e.perr && !mon_e.ferr));
          if (!mon_e.ferr) last_good[use_fast] = mon_e.b;
          check_eq("data", 32'(m_data), 32'(last_good[use_fast]));
        end
      end
    end
  end

  task automatic send_bit(input logic v);
    line = v;
    repeat (use_fast ? FAST_BIT : SLOW_BIT) @(posedge clk);
  endtask

  // One frame: start, 8 data LSB-first, optional parity, stop bits.
  // tail_high=0 leaves the line low after the first stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit par_bad, input bit tail_high);
    exp_t e;
    e.b    = b;
    e.ferr = !stop_ok;
`ifdef UART_RX_PARITY_EN
    e.perr = par_bad;
`else
    e.perr = 1'b0;
`endif
    exp_q.push_back(e);
    pushed_cnt++;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_bad);
`endif
    send_bit(stop_ok);
    if (tail_high) begin
      for (int i = 1; i < STOP_BITS; i++) send_bit(1'b1);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int ev0;
    int exp_inc;
    logic [7:0] rb;
    bit sok, pbad;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;

    // Reset state of both instances
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_data", 32'(data_s), 32'h00);
    check_eq("rst_busy", 32'(b_s), 32'd0);
    check_eq("rst_pulses", 32'({v_s, fe_s, pe_s, v_f, fe_f, pe_f}), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    exp_inc = int'((64'd115200 * 64'd16 * 64'd65536) / 64'd100000000);
    check_eq("inc_default", 32'(dut_slow.u_nco.INC), 32'(exp_inc));

    // 8'hA5 at 115200 bd
    ev0 = ev_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    wait_drain();
    @(negedge clk);
    check_eq("a5_events", 32'(ev_cnt - ev0), 32'd1);
    check_eq("a5_data", 32'(data_s), 32'hA5);

    // 300-clk glitch from idle
    ev0 = ev_cnt;
    line = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_busy_hi", 32'(b_s), 32'd1);
    repeat (290) @(posedge clk);
    line = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!b_s) break;
    end
    check_eq("glitch_busy_lo", 32'(b_s), 32'd0);
    check_eq("glitch_no_pulse", 32'(ev_cnt - ev0), 32'd0);
    repeat (50) @(posedge clk);

    // Switch to the fast instance
    use_fast = 1'b1;
    repeat (20) @(posedge clk);

    // Back-to-back frames with no idle gap
    ev0 = ev_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    wait_drain();
    check_eq("b2b_events", 32'(ev_cnt - ev0), 32'd3);

    // Stop bit low, then line stuck low
    ev0 = ev_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (5000) @(posedge clk);
    @(negedge clk);
    check_eq("ferr_busy_hold", 32'(b_f), 32'd1);
    check_eq("ferr_events", 32'(ev_cnt - ev0), 32'd1);
    check_eq("ferr_data_kept", 32'(data_f), 32'h3C);
    line = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("ferr_busy_release", 32'(b_f), 32'd0);
    repeat (60) @(posedge clk);

    // Reset in the middle of D3 of 8'h81, then 8'h42
    ev0 = ev_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    line = 1'b0;
    repeat (FAST_BIT / 2) @(posedge clk);
    rst_n = 1'b0;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_data", 32'(data_f), 32'h00);
    check_eq("midrst_busy", 32'(b_f), 32'd0);
    check_eq("midrst_slow_data", 32'(data_s), 32'h00);
    line = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    send_frame(8'h42, 1'b1, 1'b0, 1'b1);
    wait_drain();
    @(negedge clk);
    check_eq("after_rst_events", 32'(ev_cnt - ev0), 32'd1);
    check_eq("after_rst_data", 32'(data_f), 32'h42);

`ifdef UART_RX_PARITY_EN
    // 8'h07 has odd weight, so even parity wants bit 1
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    wait_drain();
`endif

    // Random traffic with occasional stop errors and short idle gaps
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom_range(0, 255));
      sok  = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      pbad = ($urandom_range(0, 3) == 0);
`else
      pbad = 1'b0;
`endif
      send_frame(rb, sok, pbad, 1'b1);
      repeat ($urandom_range(0, 2) * FAST_BIT) @(posedge clk);
    end
    wait_drain();
    repeat (100) @(posedge clk);
    @(negedge clk);
    check_eq("events_total", 32'(ev_cnt), 32'(pushed_cnt));
    check_eq("final_idle", 32'(b_f), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
